// File: rtl/alu_pkg.sv
// Shared ALU control encodings and widths, used by the ALU decoder and execute stage.
package alu_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int ALU_CTL_WIDTH = 4;
  localparam int SHAMT_W       = 5;

  // Code 4'd15 is deliberately left undefined and reported as illegal.
  typedef enum logic [ALU_CTL_WIDTH-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_XOR   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_AND   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SGE   = 4'd7,
    ALU_SGEU  = 4'd8,
    ALU_SEQ   = 4'd9,
    ALU_SNE   = 4'd10,
    ALU_SLL   = 4'd11,
    ALU_SRL   = 4'd12,
    ALU_SRA   = 4'd13,
    ALU_AUIPC = 4'd14
  } alu_ctl_e;

  function automatic logic is_shift_op(input logic [ALU_CTL_WIDTH-1:0] ctl);
    return (ctl == ALU_SLL) || (ctl == ALU_SRL) || (ctl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shifter for the ALU execute stage: one bit per cycle by default, single-cycle
// barrel shifter when ALU_FAST_SHIFT_EN is defined.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ALU_CTL_WIDTH-1:0] kind,
  input  logic [XLEN-1:0]          a,
  input  logic [SHAMT_W-1:0]       shamt,
  output logic [XLEN-1:0]          comb_result,
  output logic [XLEN-1:0]          step_result,
  output logic                     last
);

`ifdef ALU_FAST_SHIFT_EN
  logic unused_seq;
  assign unused_seq = ^{clk, rst, start};

  always_comb begin
    case (kind)
      ALU_SLL: comb_result = a << shamt;
      ALU_SRA: comb_result = $unsigned($signed(a) >>> shamt);
      default: comb_result = a >> shamt;
    endcase
  end

  assign step_result = '0;
  assign last        = 1'b0;
`else
  logic [XLEN-1:0]          val;
  logic [SHAMT_W-1:0]       cnt;
  logic [ALU_CTL_WIDTH-1:0] kind_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      val    <= '0;
      cnt    <= '0;
      kind_q <= ALU_ADD;
    end else if (start) begin
      val    <= a;
      cnt    <= shamt;
      kind_q <= kind;
    end else if (cnt != '0) begin
      val <= step_result;
      cnt <= cnt - SHAMT_W'(1);
    end
  end

  always_comb begin
    case (kind_q)
      ALU_SLL: step_result = {val[XLEN-2:0], 1'b0};
      ALU_SRA: step_result = {val[XLEN-1], val[XLEN-1:1]};
      default: step_result = {1'b0, val[XLEN-1:1]};
    endcase
  end

  // step_result on the cycle cnt==1 is the final shifted value.
  assign last        = (cnt == SHAMT_W'(1));
  assign comb_result = a;
`endif

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage with valid/ready handshakes and a multi-cycle shift path.
// Build option: ALU_FAST_SHIFT_EN selects a single-cycle barrel shifter.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int TAG_W = 5
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ALU_CTL_WIDTH-1:0] in_ctl,
  input  logic [XLEN-1:0]          in_a,
  input  logic [XLEN-1:0]          in_b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_illegal
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state;
  logic             accept;
  logic             go_shift;
  logic             illegal;
  logic [XLEN-1:0]  alu_res;
  logic [XLEN-1:0]  shift_comb;
  logic [XLEN-1:0]  shift_step;
  logic             shift_last;
  logic [TAG_W-1:0] tag_q;

  // Handshake: a transfer happens on a rising edge where valid && ready;
  // a producer holds its payload stable while valid is high and ready is low.
  assign in_ready = !rst && (state == S_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

`ifdef ALU_FAST_SHIFT_EN
  assign go_shift = 1'b0;
`else
  assign go_shift = is_shift_op(in_ctl) && (in_b[SHAMT_W-1:0] != '0);
`endif

  alu_shifter #(.XLEN(XLEN)) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .start       (accept && go_shift),
    .kind        (in_ctl),
    .a           (in_a),
    .shamt       (in_b[SHAMT_W-1:0]),
    .comb_result (shift_comb),
    .step_result (shift_step),
    .last        (shift_last)
  );

  always_comb begin
    alu_res = '0;
    illegal = 1'b0;
    case (in_ctl)
      ALU_ADD, ALU_AUIPC:         alu_res    = in_a + in_b;
      ALU_SUB:                    alu_res    = in_a - in_b;
      ALU_XOR:                    alu_res    = in_a ^ in_b;
      ALU_OR:                     alu_res    = in_a | in_b;
      ALU_AND:                    alu_res    = in_a & in_b;
      ALU_SLT:                    alu_res[0] = $signed(in_a) < $signed(in_b);
      ALU_SLTU:                   alu_res[0] = in_a < in_b;
      ALU_SGE:                    alu_res[0] = $signed(in_a) >= $signed(in_b);
      ALU_SGEU:                   alu_res[0] = in_a >= in_b;
      ALU_SEQ:                    alu_res[0] = in_a == in_b;
      ALU_SNE:                    alu_res[0] = in_a != in_b;
      ALU_SLL, ALU_SRL, ALU_SRA:  alu_res    = shift_comb;
      default:                    illegal    = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_tag     <= '0;
      out_illegal <= 1'b0;
      tag_q       <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (go_shift) begin
              state <= S_SHIFT;
              tag_q <= in_tag;
            end else begin
              out_valid   <= 1'b1;
              out_result  <= alu_res;
              out_tag     <= in_tag;
              out_illegal <= illegal;
            end
          end
        end
        S_SHIFT: begin
          // out_valid is already low here: acceptance required the output slot free.
          if (shift_last) begin
            state       <= S_IDLE;
            out_valid   <= 1'b1;
            out_result  <= shift_step;
            out_tag     <= tag_q;
            out_illegal <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
